// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit
// Program-counter and fetch-sequencing stage. Holds the registered PC that
// addresses program memory, advances it one word per unstalled cycle,
// applies absolute branch/jump redirects, and parks in a sticky FAULT state
// once the program-memory decoder reports the PC is outside its window.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous, active-high reset (overrides all inputs)
//   iStall         hold PC this cycle; a simultaneous branch is dropped
//   iBranchEn      redirect request, loads iBranchTarget
//   iBranchTarget  absolute redirect address
//   CS_P           chip-select from the program-memory decoder for ADDR_Prog
//   ADDR_Prog      registered PC driven to the program-memory decoder
//   oPCPlus        ADDR_Prog + PC_STEP (link value), combinational
//   oFetchValid    ADDR_Prog is a valid fetch this cycle
//   oFault         sticky fetch-fault flag
//   oState         debug state: BOOT=0, RUN=1, FAULT=2
module prog_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000410,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iStall,
  input  logic        iBranchEn,
  input  logic [31:0] iBranchTarget,
  input  logic        CS_P,
  output logic [31:0] ADDR_Prog,
  output logic [31:0] oPCPlus,
  output logic        oFetchValid,
  output logic        oFault,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus;

  // Modulo-2^32 increment; wrap past 32'hFFFFFFFF is intentional and the
  // resulting out-of-window address is caught by CS_P on the next cycle.
  assign pc_plus = pc_q + PC_STEP;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // Chip-select loss wins over stall and branch; the bad address is
        // kept on ADDR_Prog for diagnosis.
        if (!CS_P) begin
          state_d = FAULT;
        end else if (!iStall) begin
          pc_d = iBranchEn ? iBranchTarget : pc_plus;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  assign ADDR_Prog   = pc_q;
  assign oPCPlus     = pc_plus;
  assign oFetchValid = (state_q == RUN) & CS_P & ~iStall;
  assign oFault      = (state_q == FAULT);
  assign oState      = state_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
module tb_prog_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h00000410;
  localparam logic [31:0] WIN_LO = 32'h00000410;
  localparam logic [31:0] WIN_HI = 32'h0000080F;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_en;
  logic [31:0] br_tgt;
  logic        cs_p;
  logic        cs_all;
  logic [31:0] addr;
  logic [31:0] pcplus;
  logic        fvalid;
  logic        fault;
  logic [1:0]  st;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural PC and state (0 BOOT, 1 RUN, 2 FAULT)
  logic [31:0] m_pc;
  int          m_st;

  prog_fetch_unit #(
    .RESET_PC(32'h00000410),
    .PC_STEP (32'd1)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .iStall       (stall),
    .iBranchEn    (br_en),
    .iBranchTarget(br_tgt),
    .CS_P         (cs_p),
    .ADDR_Prog    (addr),
    .oPCPlus      (pcplus),
    .oFetchValid  (fvalid),
    .oFault       (fault),
    .oState       (st)
  );

  // Program-memory decoder stand-in; cs_all opens the whole address space.
  assign cs_p = cs_all | ((addr >= WIN_LO) && (addr <= WIN_HI));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_cs(input logic [31:0] a);
    return cs_all || ((a >= WIN_LO) && (a <= WIN_HI));
  endfunction

  function automatic logic m_valid();
    return (m_st == 1) && m_cs(m_pc) && !stall;
  endfunction

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r; stall = s; br_en = b; br_tgt = t;
    #1;
  endtask

  // Advance one clock; model the edge from the rules using the inputs as driven.
  task automatic tick();
    logic [31:0] npc;
    int          nst;
    npc = m_pc;
    nst = m_st;
    if (rst) begin
      npc = RST_PC; nst = 0;
    end else if (m_st == 0) begin
      nst = 1;
    end else if (m_st == 1) begin
      if (!m_cs(m_pc))  nst = 2;
      else if (stall)   npc = m_pc;
      else if (br_en)   npc = br_tgt;
      else              npc = m_pc + 32'd1;
    end
    @(posedge clk);
    #1;
    m_pc = npc;
    m_st = nst;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'h0);
    tick(); tick();
    n_cmp++; if (addr !== 32'h410) begin n_bad++; $display("FAIL reset_addr: got %h want %h", addr, 32'h410); end
    n_cmp++; if (st !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    drive(0, 0, 0, 32'h0);
    n_cmp++; if (fvalid !== 1'b0) begin n_bad++; $display("FAIL boot_valid: got %b want 0", fvalid); end
    tick();
    n_cmp++; if (st !== 2'd1) begin n_bad++; $display("FAIL run_state: got %0d want 1", st); end
    n_cmp++; if (fvalid !== 1'b1 || addr !== 32'h410) begin n_bad++; $display("FAIL first_fetch: got valid=%b addr=%h want 1 410", fvalid, addr); end
    tick();
    n_cmp++; if (addr !== 32'h411) begin n_bad++; $display("FAIL seq1: got %h want 411", addr); end
    tick();
    n_cmp++; if (addr !== 32'h412) begin n_bad++; $display("FAIL seq2: got %h want 412", addr); end
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 32'h420); tick();
    for (int unsigned c = 0; c < 3; c++) begin
      if (c == 1) drive(0, 1, 1, 32'h500);
      else        drive(0, 1, 0, 32'h0);
      n_cmp++; if (fvalid !== 1'b0) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 0", c, fvalid); end
      tick();
      n_cmp++; if (addr !== 32'h420 || pcplus !== 32'h421) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h/%h want 420/421", c, addr, pcplus); end
    end
    drive(0, 0, 0, 32'h0);
    n_cmp++; if (fvalid !== 1'b1) begin n_bad++; $display("FAIL stall_release_valid: got %b want 1", fvalid); end
    tick();
    n_cmp++; if (addr !== 32'h421) begin n_bad++; $display("FAIL stall_release: got %h want 421", addr); end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 32'h430); tick();
    drive(0, 0, 1, 32'h600); tick();
    n_cmp++; if (addr !== 32'h600 || pcplus !== 32'h601) begin n_bad++; $display("FAIL branch: got %h/%h want 600/601", addr, pcplus); end
    drive(0, 0, 0, 32'h0); tick();
    n_cmp++; if (addr !== 32'h601) begin n_bad++; $display("FAIL branch_next: got %h want 601", addr); end
  endtask

  task automatic test_end_of_window();
    drive(0, 0, 1, 32'h80A); tick();
    drive(0, 0, 0, 32'h0);
    for (int unsigned c = 0; c < 5; c++) tick();
    n_cmp++; if (addr !== 32'h80F || fvalid !== 1'b1) begin n_bad++; $display("FAIL eow_last: got %h valid=%b want 80f 1", addr, fvalid); end
    tick();
    n_cmp++; if (addr !== 32'h810 || st !== 2'd1 || fvalid !== 1'b0) begin n_bad++; $display("FAIL eow_out: got %h st=%0d valid=%b want 810 1 0", addr, st, fvalid); end
    tick();
    n_cmp++; if (addr !== 32'h810 || st !== 2'd2 || fault !== 1'b1) begin n_bad++; $display("FAIL eow_fault: got %h st=%0d f=%b want 810 2 1", addr, st, fault); end
    for (int unsigned c = 0; c < 4; c++) begin
      drive(0, c[0], c[1] | c[0], 32'h450 + c);
      n_cmp++; if (fvalid !== 1'b0) begin n_bad++; $display("FAIL fault_valid[%0d]: got %b want 0", c, fvalid); end
      tick();
      n_cmp++; if (addr !== 32'h810 || st !== 2'd2 || fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky[%0d]: got %h st=%0d f=%b want 810 2 1", c, addr, st, fault); end
    end
  endtask

  task automatic test_oow_branch();
    drive(1, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 32'h0); tick();
    drive(0, 0, 1, 32'hF); tick();
    drive(0, 0, 0, 32'h0);
    n_cmp++; if (addr !== 32'hF || st !== 2'd1 || fvalid !== 1'b0) begin n_bad++; $display("FAIL oow_load: got %h st=%0d valid=%b want f 1 0", addr, st, fvalid); end
    tick();
    n_cmp++; if (addr !== 32'hF || st !== 2'd2 || fault !== 1'b1) begin n_bad++; $display("FAIL oow_fault: got %h st=%0d f=%b want f 2 1", addr, st, fault); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 32'h0); tick();
    n_cmp++; if (addr !== 32'h410 || st !== 2'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL rst_from_fault: got %h st=%0d f=%b want 410 0 0", addr, st, fault); end
    drive(0, 0, 0, 32'h0); tick();
    drive(0, 0, 1, 32'h700); tick();
    drive(0, 1, 0, 32'h0); tick();
    n_cmp++; if (addr !== 32'h700) begin n_bad++; $display("FAIL stalled_700: got %h want 700", addr); end
    drive(1, 1, 1, 32'h123); tick();
    n_cmp++; if (addr !== 32'h410 || st !== 2'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL rst_from_stall: got %h st=%0d f=%b want 410 0 0", addr, st, fault); end
  endtask

  task automatic test_wrap();
    cs_all = 1'b1;
    drive(0, 0, 0, 32'h0); tick();
    drive(0, 0, 1, 32'hFFFF_FFFF); tick();
    n_cmp++; if (addr !== 32'hFFFF_FFFF || pcplus !== 32'h0) begin n_bad++; $display("FAIL wrap_top: got %h/%h want ffffffff/0", addr, pcplus); end
    drive(0, 0, 0, 32'h0); tick();
    n_cmp++; if (addr !== 32'h0 || pcplus !== 32'h1 || st !== 2'd1) begin n_bad++; $display("FAIL wrap_zero: got %h/%h st=%0d want 0/1 1", addr, pcplus, st); end
    cs_all = 1'b0;
    drive(0, 0, 0, 32'h0); tick();
    n_cmp++; if (st !== 2'd2 || addr !== 32'h0) begin n_bad++; $display("FAIL wrap_fault: got st=%0d %h want 2 0", st, addr); end
    drive(1, 0, 0, 32'h0); tick();
  endtask

  task automatic test_random();
    logic        r, s, b;
    logic [31:0] t;
    for (int unsigned i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 29) == 0) || (m_st == 2 && $urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : (32'h400 + $urandom_range(0, 32'h420));
      drive(r, s, b, t);
      n_cmp++; if (fvalid !== m_valid()) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, fvalid, m_valid()); end
      tick();
      n_cmp++;
      if (addr !== m_pc || pcplus !== m_pc + 32'd1 || st !== 2'(m_st) || fault !== (m_st == 2)) begin
        n_bad++;
        $display("FAIL rnd_state[%0d]: got addr=%h plus=%h st=%0d f=%b want %h %h %0d %b",
                 i, addr, pcplus, st, fault, m_pc, m_pc + 32'd1, m_st, (m_st == 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_tgt = '0; cs_all = 1'b0;
    m_pc = RST_PC; m_st = 0;
    @(posedge clk); #1;
    test_reset();
    test_stall();
    test_branch();
    test_end_of_window();
    test_oow_branch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_fetch_unit.md
# prog_fetch_unit

Program-counter and fetch-sequencing stage that drives `ADDR_Prog` into the program-memory address decoder and consumes that decoder's `CS_P` chip-select. Holds the registered PC, advances it by one word per cycle, and applies branch/jump redirects and pipeline stalls. Halts in a sticky fault state when the PC leaves the program window. It is the first stage of the instruction path, upstream of program-memory decode and instruction fetch.

## Interface
- `RESET_PC`, 32'h00000410, PC value loaded on reset (first program word)
- `PC_STEP`, 32'd1, increment applied per advancing cycle (word addressing)
- `CLK`  input  1  single clock; all state updates on rising edge
- `RST`  input  1  synchronous, active-high reset
- `iStall`  input  1  hold PC this cycle (downstream not ready)
- `iBranchEn`  input  1  redirect request; load `iBranchTarget`
- `iBranchTarget`  input  32  absolute redirect address
- `CS_P`  input  1  chip-select returned by program-memory decoder for current `ADDR_Prog`
- `ADDR_Prog`  output  32  registered PC presented to the program-memory decoder
- `oPCPlus`  output  32  `ADDR_Prog + PC_STEP`, combinational (link value for jump-and-link)
- `oFetchValid`  output  1  current `ADDR_Prog` is a valid fetch
- `oFault`  output  1  sticky fetch-fault flag
- `oState`  output  2  state encoding for debug: BOOT=0, RUN=1, FAULT=2

## Operation
- States: BOOT, RUN, FAULT. Encoding 3 is unreachable; if entered, next state is FAULT.
- Reset (`RST`=1 at an edge, any state): `ADDR_Prog`=`RESET_PC`, state=BOOT, `oFault`=0, `oFetchValid`=0. Reset overrides every other input, including mid-stall and mid-branch.
- BOOT: PC unchanged, `oFetchValid`=0. Next state is RUN unconditionally. `iStall` and `iBranchEn` are ignored in BOOT.
- RUN, priority order per edge:
  1. `CS_P`=0: next state FAULT, PC held.
  2. `iStall`=1: PC held, and a simultaneous `iBranchEn` is dropped. The requester must keep `iBranchEn` asserted until a non-stalled cycle.
  3. `iBranchEn`=1: PC ← `iBranchTarget`.
  4. Otherwise: PC ← PC + `PC_STEP`.
- FAULT: PC frozen at the offending address, `oFault`=1, `oFetchValid`=0. Only `RST` exits FAULT.
- `oFetchValid` = (state==RUN) & `CS_P` & ~`iStall`, combinational.
- Arithmetic is 32-bit modulo 2^32. Increment from 32'hFFFFFFFF wraps to 0. The out-of-window result is then caught by `CS_P` on the following cycle.
- A branch target outside the window is loaded normally. FAULT is entered on the next cycle via `CS_P`=0.
- `oPCPlus` is valid in every state. It is also computed modulo 2^32.

## Timing
- `ADDR_Prog` changes only on `CLK` rising edges.
- `CS_P` is a combinational function of `ADDR_Prog` and must settle within the same cycle.
- Reset latency: the first valid fetch (`oFetchValid`=1 at `RESET_PC`) occurs in the second cycle after `RST` deasserts; the first cycle is BOOT.
- Sequential throughput is one new address per cycle while unstalled.
- Branch latency: `iBranchEn` sampled at edge N gives `ADDR_Prog`=target from edge N onward, one cycle of redirect.
- Fault detection: `CS_P`=0 in RUN sets `oFault` at the next edge. The bad address stays on `ADDR_Prog`.
- During stall, `ADDR_Prog` and `oPCPlus` are stable for the entire stall.

## Test plan
- Reset/boot: assert `RST` 2 cycles, release → cycle 1: BOOT, `ADDR_Prog`=0x410, valid=0; cycle 2: RUN, valid=1; cycles 3, 4: `ADDR_Prog`=0x411, 0x412.
- Stall: in RUN at 0x420, `iStall`=1 for 3 cycles, with `iBranchEn`=1 and target 0x500 on the 2nd cycle → PC stays 0x420, branch dropped, valid=0. Then release with no branch → 0x421.
- Branch: at 0x430, `iBranchEn`=1, target 0x600 → next `ADDR_Prog`=0x600 and `oPCPlus`=0x601, then 0x601.
- End of window: run sequentially to 0x80F → next 0x810, `CS_P`=0, then FAULT with `oFault`=1, `ADDR_Prog` frozen at 0x810, `oState`=2. Any `iBranchEn`/`iStall` activity leaves it unchanged.
- Out-of-window branch: branch to 0x0000000F → one cycle at 0xF with valid=0, then FAULT.
- Reset mid-operation: assert `RST` while in FAULT, and separately while stalled at 0x700 → `ADDR_Prog`=0x410, `oFault`=0, state BOOT on the next edge.
